// File: rtl/uart_rx.sv
// Receiver for the inverted-polarity serial line (idle 0, start 1, data inverted, stop 0).
// Oversamples at 16x via sample_clk and hands each byte over through a valid/ack register.
module uart_rx (
    input  logic       ref_clk,
    input  logic       reset_n,
    input  logic       sample_clk,
    input  logic       line,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e     r_state, w_state_d;
    logic       r_sync1, r_sync2;
    logic [3:0] r_tcnt, w_tcnt_d;
    logic [2:0] r_bidx, w_bidx_d;
    logic [7:0] r_shift, w_shift_d;
    logic [7:0] r_data, w_data_d;
    logic       r_valid, w_valid_d;
    logic       r_frame_err, w_frame_err_d;
    logic       r_overrun, w_overrun_d;
    logic       w_done;

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= StIdle;
            r_tcnt      <= 4'd0;
            r_bidx      <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= line;
            r_sync2     <= r_sync1;
            r_state     <= w_state_d;
            r_tcnt      <= w_tcnt_d;
            r_bidx      <= w_bidx_d;
            r_shift     <= w_shift_d;
            r_data      <= w_data_d;
            r_valid     <= w_valid_d;
            r_frame_err <= w_frame_err_d;
            r_overrun   <= w_overrun_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_tcnt_d  = r_tcnt;
        w_bidx_d  = r_bidx;
        w_shift_d = r_shift;
        w_done    = 1'b0;
        if (sample_clk) begin
            unique case (r_state)
                StIdle: begin
                    if (r_sync2) begin
                        w_state_d = StStart;
                        w_tcnt_d  = 4'd0;
                    end
                end
                StStart: begin
                    w_tcnt_d = r_tcnt + 4'd1;
                    if (r_tcnt == 4'd7) begin
                        // Mid-start check rejects short glitches without touching any flag.
                        if (r_sync2) begin
                            w_state_d = StData;
                            w_tcnt_d  = 4'd0;
                            w_bidx_d  = 3'd0;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end
                end
                StData: begin
                    w_tcnt_d = r_tcnt + 4'd1;
                    if (r_tcnt == 4'd15) begin
                        w_shift_d[r_bidx] = ~r_sync2;
                        w_bidx_d          = r_bidx + 3'd1;
                        if (r_bidx == 3'd7) begin
                            w_state_d = StStop;
                        end
                    end
                end
                StStop: begin
                    w_tcnt_d = r_tcnt + 4'd1;
                    if (r_tcnt == 4'd15) begin
                        w_done    = 1'b1;
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Byte completion takes priority over a same-cycle ack.
    always_comb begin
        w_data_d      = r_data;
        w_valid_d     = r_valid;
        w_frame_err_d = r_frame_err;
        w_overrun_d   = r_overrun;
        if (w_done) begin
            w_data_d      = r_shift;
            w_valid_d     = 1'b1;
            w_frame_err_d = r_sync2;
            w_overrun_d   = r_overrun | r_valid;
        end else if (ack) begin
            w_valid_d   = 1'b0;
            w_overrun_d = 1'b0;
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = (r_state != StIdle);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames built bit by bit on the inverted line, checked against
// hand-computed bytes and flags.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       ref_clk    = 1'b0;
    logic       reset_n    = 1'b0;
    logic       sample_clk = 1'b0;
    logic       line       = 1'b0;
    logic       ack        = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int          n_total = 0;
    int          n_bad   = 0;
    int unsigned div     = 0;
    logic        race_done;

    uart_rx dut (
        .ref_clk   (ref_clk),
        .reset_n   (reset_n),
        .sample_clk(sample_clk),
        .line      (line),
        .ack       (ack),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 ref_clk = ~ref_clk;

    // One-cycle tick every 4 ref_clk cycles, changed away from the active edge.
    always @(negedge ref_clk) begin
        div        = (div + 1) % 4;
        sample_clk = (div == 0);
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%02h exp=0x%02h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ref_clk);
            while (!sample_clk) @(posedge ref_clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        line = 1'b1;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            line = ~b[i];
            wait_ticks(16);
        end
        line = stop_bit;
        wait_ticks(16);
        line = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(posedge ref_clk);
        #1;
        ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge ref_clk);
        #1;
        check_eq("rst_data", data, 8'h00);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ferr", frame_err, 1'b0);
        check_eq("rst_ovr", overrun, 1'b0);
        reset_n = 1'b1;
        wait_ticks(4);

        send_frame(8'hA5, 1'b0);
        check_eq("a5_data", data, 8'hA5);
        check_eq("a5_valid", valid, 1'b1);
        check_eq("a5_ferr", frame_err, 1'b0);
        check_eq("a5_busy", busy, 1'b0);
        pulse_ack();
        check_eq("a5_ack_valid", valid, 1'b0);

        send_frame(8'h00, 1'b0);
        check_eq("b00_data", data, 8'h00);
        check_eq("b00_valid", valid, 1'b1);
        pulse_ack();
        send_frame(8'hFF, 1'b0);
        check_eq("bff_data", data, 8'hFF);
        check_eq("bff_ferr", frame_err, 1'b0);
        check_eq("bff_ovr", overrun, 1'b0);
        pulse_ack();
        check_eq("bff_ack_valid", valid, 1'b0);

        wait_ticks(4);
        line = 1'b1;
        wait_ticks(3);
        check_eq("glitch_busy_hi", busy, 1'b1);
        wait_ticks(2);
        line = 1'b0;
        wait_ticks(20);
        check_eq("glitch_busy_lo", busy, 1'b0);
        check_eq("glitch_valid", valid, 1'b0);
        check_eq("glitch_data", data, 8'hFF);

        send_frame(8'h3C, 1'b1);
        check_eq("3c_data", data, 8'h3C);
        check_eq("3c_valid", valid, 1'b1);
        check_eq("3c_ferr", frame_err, 1'b1);
        // The held stop level re-triggers a start that must die as a glitch.
        wait_ticks(20);
        check_eq("3c_busy_after", busy, 1'b0);
        pulse_ack();
        send_frame(8'h12, 1'b0);
        check_eq("12_data", data, 8'h12);
        check_eq("12_ferr", frame_err, 1'b0);
        pulse_ack();

        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        check_eq("22_data", data, 8'h22);
        check_eq("22_valid", valid, 1'b1);
        check_eq("22_ovr", overrun, 1'b1);
        pulse_ack();
        check_eq("22_ack_valid", valid, 1'b0);
        check_eq("22_ack_ovr", overrun, 1'b0);

        race_done = 1'b0;
        fork
            send_frame(8'h33, 1'b0);
            begin
                wait_ticks(145);
                ack = 1'b1;
                for (int k = 0; k < 200 && !race_done; k++) begin
                    @(posedge ref_clk);
                    #1;
                    if (!busy) race_done = 1'b1;
                end
                ack = 1'b0;
            end
        join
        check_eq("33_race_seen", race_done, 1'b1);
        check_eq("33_valid", valid, 1'b1);
        check_eq("33_data", data, 8'h33);
        check_eq("33_ovr", overrun, 1'b0);

        line = 1'b1;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            line = ~i[0];
            wait_ticks(16);
        end
        line = 1'b0;
        wait_ticks(8);
        check_eq("mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("mrst_data", data, 8'h00);
        check_eq("mrst_valid", valid, 1'b0);
        check_eq("mrst_busy", busy, 1'b0);
        check_eq("mrst_ferr", frame_err, 1'b0);
        check_eq("mrst_ovr", overrun, 1'b0);
        repeat (3) @(posedge ref_clk);
        #1;
        reset_n = 1'b1;
        wait_ticks(4);
        send_frame(8'h5A, 1'b0);
        check_eq("5a_data", data, 8'h5A);
        check_eq("5a_valid", valid, 1'b1);
        check_eq("5a_ferr", frame_err, 1'b0);
        check_eq("5a_ovr", overrun, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the inverted-polarity RS232 line driven by our transmitter: line idles at 0, start bit is 1, data bits are sent LSB first and inverted, stop bit is 0. It oversamples the line at 16x baud using a single-cycle tick strobe, recovers 8-bit bytes, and presents each byte to the downstream consumer through a valid/ack holding register. It sits between the board RX pin and the command or loopback logic.

## Interface
- No parameters. Fixed format: 8 data bits, no parity, 1 stop bit, 16x oversampling.
- ref_clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sample_clk  input  1  16x-baud tick, one ref_clk cycle wide. Logic advances only on cycles where it is 1.
- line  input  1  raw serial input, asynchronous to ref_clk. Idle is 0.
- ack  input  1  consumer has taken data; clears valid.
- data  output  8  last received byte, de-inverted. Changes only when a byte completes.
- valid  output  1  level; set when a byte completes, cleared by ack.
- busy  output  1  1 from start detection until the end of the stop-bit sample.
- frame_err  output  1  sticky; set when a stop bit samples as 1. Cleared by the next error-free byte.
- overrun  output  1  sticky; set when a byte completes while valid=1. Cleared by ack.

## Operation
- Synchronizer: two flops on line (sync = second flop), reset to 0. All decisions use sync.
- Counters: 4-bit tick counter (tcnt) and 3-bit bit index (bidx).
- FSM states and transitions. Every transition below happens only on a cycle where sample_clk=1.
  - S_IDLE: busy=0. If sync=1, go to S_START with tcnt=0 and busy=1.
  - S_START: tcnt increments each tick. When tcnt==7, check sync. If sync=0, the start is a glitch: go to S_IDLE, busy=0, no flags change. If sync=1, go to S_DATA with tcnt=0 and bidx=0.
  - S_DATA: tcnt increments each tick. When tcnt==15, shift[bidx] is loaded with ~sync, bidx increments, and tcnt wraps to 0. After bidx==7 is sampled, go to S_STOP.
  - S_STOP: when tcnt==15, complete the byte and go to S_IDLE with busy=0.
    - data is loaded from shift.
    - valid is set to 1.
    - frame_err is set to 1 if sync=1, otherwise cleared to 0.
    - overrun is set if valid was already 1.
- A byte with a framing error is still delivered: data is updated, valid=1, frame_err=1.
- The receiver does not wait for ack. A new byte overwrites data.
- ack=1 clears valid and overrun on the next edge.
- ack in the same cycle as byte completion: the completion wins. valid stays 1, the new data is loaded, and overrun is set from the pre-ack value of valid.
- ack while valid=0 has no effect.
- sample_clk=0: all counters and state hold. ack is still honoured.
- A line held at 1 with no stop bit: after the framing error the FSM returns to S_IDLE and immediately detects a new start on the next tick. No break detection.

## Timing
- Reset values: data=0x00, valid=0, busy=0, frame_err=0, overrun=0. FSM to S_IDLE, counters to 0, synchronizer to 0.
- Reset asserted mid-frame aborts immediately. No partial byte is delivered.
- Synchronizer latency: 2 ref_clk cycles from line to sync.
- Start detection to data-bit samples: each data bit is sampled 8 + 16·(n+1) ticks after the start-detect tick, i.e. at the bit centre.
- Stop bit is sampled 8 + 16·9 = 152 ticks after start detection.
- valid, data, frame_err and overrun update at the ref_clk edge of the stop-sample tick.
- busy falls on that same edge.
- Back-to-back frames are supported with zero idle time between them.

## Test plan
- Byte 0xA5, 16 ticks per bit, sample_clk every 4 ref_clk cycles → data=0xA5, valid=1, frame_err=0, busy low after stop; then ack → valid=0.
- Bytes 0x00 and 0xFF back-to-back, ack after each → data=0x00 then 0xFF, no flags set.
- Glitch: line=1 for 5 ticks then 0 → busy pulses and returns to 0; valid stays 0, data unchanged.
- Byte 0x3C with stop bit driven as 1 → data=0x3C, valid=1, frame_err=1. A following good 0x12 clears frame_err.
- Bytes 0x11 then 0x22 without ack → data=0x22, overrun=1. ack → valid=0, overrun=0. ack coincident with completion of a third byte 0x33 → valid=1, data=0x33.
- Assert reset_n low during bit 4 of a frame → all outputs return to reset values. A subsequent 0x5A is received correctly.
